// File: rtl/zeroriscy_bnn_array.sv
// zeroriscy_bnn_array: NCORE-lane binarised-NN datapath (XNOR-popcount, max-pool, normalise, sign).
// Define ZR_BNN_SAT_EN to clamp ACC/NORM results instead of wrapping them.
module zeroriscy_bnn_array #(
    parameter int NCORE      = 32,
    parameter int DW         = 32,
    parameter int ACCW       = 16,
    parameter int PDEPTH     = 256,
    parameter int NORM_SHIFT = 6
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        bnn_en_i,
    input  logic [2:0]                                  bnn_operator_i,
    input  logic [31:0]                                 bnn_addr_i,
    input  logic [31:0]                                 bnn_data_i,
    output logic [31:0]                                 bnn_result_o,
    output logic                                        bnn_ready_o,
    input  logic                                        prm_we_i,
    input  logic [$clog2(PDEPTH)-1:0]                   prm_waddr_i,
    input  logic [((NCORE > 1) ? $clog2(NCORE) : 1)-1:0] prm_lane_i,
    input  logic [DW-1:0]                               prm_wdata_i
);
    localparam int AW = $clog2(PDEPTH);
    localparam int LW = (NCORE > 1) ? $clog2(NCORE) : 1;
    localparam int XW = (DW < ACCW) ? DW : ACCW;
    localparam int EW = ACCW + NORM_SHIFT + 2;
    localparam logic signed [ACCW-1:0] POOL_MIN = {1'b1, {(ACCW-1){1'b0}}};

    typedef enum logic [2:0] {
        OP_INI = 3'd0, OP_ACC = 3'd1, OP_POOL = 3'd2, OP_NORM = 3'd3, OP_ACTIV = 3'd4, OP_NOP = 3'd7
    } op_e;
    typedef enum logic [1:0] {S_IDLE, S_W1, S_W2} state_e;

    function automatic logic signed [ACCW-1:0] sext(input logic [DW-1:0] v);
        return ACCW'($signed(v[XW-1:0]));
    endfunction

    // Wide intermediate results are narrowed back to ACCW by clamping or by plain truncation.
    function automatic logic signed [ACCW-1:0] fit(input logic signed [EW-1:0] v);
`ifdef ZR_BNN_SAT_EN
        logic signed [EW-1:0] hi;
        logic signed [EW-1:0] lo;
        hi = $signed({{(EW-ACCW+1){1'b0}}, {(ACCW-1){1'b1}}});
        lo = $signed({{(EW-ACCW+1){1'b1}}, {(ACCW-1){1'b0}}});
        if (v > hi) return hi[ACCW-1:0];
        if (v < lo) return lo[ACCW-1:0];
`endif
        return $signed(v[ACCW-1:0]);
    endfunction

    state_e                     state, state_nx;
    logic                       accept;
    op_e                        op_in, s1_op, s2_op;
    logic [DW-1:0]              s1_data;
    logic [NCORE-1:0][DW-1:0]   s1_row;
    logic [NCORE-1:0][DW-1:0]   ram [PDEPTH];
    logic [LW-1:0]              wlane;
    logic [NCORE-1:0]           res;
    logic                       unused_ok;

    assign unused_ok = ^bnn_addr_i;
    if (DW < 32) begin : g_dpad
        logic unused_data;
        assign unused_data = ^bnn_data_i[31:DW];
    end

    assign accept = bnn_en_i & bnn_ready_o;

    always_comb begin
        op_in = OP_NOP;
        if (accept && bnn_operator_i <= 3'd4) op_in = op_e'(bnn_operator_i);
    end

    // ACTIV stalls issue until its result lands, so the next op always sees it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        bnn_ready_o = 1'b0;
        case (state)
            S_IDLE: begin
                bnn_ready_o = 1'b1;
                if (bnn_en_i && bnn_operator_i == 3'd4) state_nx = S_W1;
            end
            S_W1:    state_nx = S_W2;
            S_W2:    state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_op   <= OP_NOP;
            s2_op   <= OP_NOP;
            s1_data <= '0;
        end else begin
            s1_op <= op_in;
            s2_op <= s1_op;
            if (accept) s1_data <= bnn_data_i[DW-1:0];
        end
    end

    // Read-first: a same-edge write is not seen by the row captured here.
    assign wlane = LW'(NCORE - 1) - prm_lane_i;
    always_ff @(posedge clk) begin
        if (prm_we_i) ram[prm_waddr_i][wlane] <= prm_wdata_i;
        if (accept)   s1_row <= ram[bnn_addr_i[AW-1:0]];
    end

    for (genvar g = 0; g < NCORE; g++) begin : g_lane
        logic [DW-1:0]          w, x, x_d;
        logic signed [ACCW-1:0] acc, pool, acc_nx, pool_nx;
        logic                   r;

        assign w = s1_row[NCORE-1-g];

        always_comb begin
            x_d = x;
            case (s1_op)
                OP_INI, OP_POOL: x_d = s1_data;
                OP_ACC:          x_d = ~(s1_data ^ w);
                OP_NORM:         x_d = w;
                default:         x_d = x;
            endcase
        end

        always_comb begin
            acc_nx  = acc;
            pool_nx = pool;
            case (s2_op)
                OP_INI: begin
                    acc_nx  = sext(x);
                    pool_nx = POOL_MIN;
                end
                OP_ACC:  acc_nx = fit(EW'(acc) + EW'(2 * $countones(x)));
                OP_POOL: begin
                    if (acc > pool) pool_nx = acc;
                    acc_nx = sext(x);
                end
                OP_NORM: pool_nx = fit((EW'(pool) <<< NORM_SHIFT) - EW'(sext(x)));
                default: ;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                x    <= '0;
                acc  <= '0;
                pool <= POOL_MIN;
                r    <= 1'b0;
            end else begin
                x    <= x_d;
                acc  <= acc_nx;
                pool <= pool_nx;
                if (s2_op == OP_ACTIV) r <= pool[ACCW-1];
            end
        end

        assign res[g] = r;
    end

    assign bnn_result_o = 32'(res);
endmodule

// File: tb/tb_zeroriscy_bnn_array.sv
// Directed bench for zeroriscy_bnn_array: behavioural lane model feeds an ACTIV result scoreboard.
module tb_zeroriscy_bnn_array;
    localparam int NCORE = 32;
`ifdef ZR_BNN_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam logic [31:0] D = 32'hA5A5_A5A5;

    logic        clk = 1'b0, rst_n = 1'b1, bnn_en = 1'b0;
    logic [2:0]  opr = '0;
    logic [31:0] addr = '0, data = '0, result;
    logic        ready;
    logic        prm_we = 1'b0;
    logic [7:0]  prm_waddr = '0;
    logic [4:0]  prm_lane = '0;
    logic [31:0] prm_wdata = '0;

    int          n_chk = 0, n_err = 0;
    logic [31:0] sb[$];
    int          m_acc[NCORE], m_pool[NCORE];
    logic [31:0] m_w[8][NCORE];
    logic [31:0] m_res;

    zeroriscy_bnn_array dut (
        .clk(clk), .rst_n(rst_n), .bnn_en_i(bnn_en), .bnn_operator_i(opr),
        .bnn_addr_i(addr), .bnn_data_i(data), .bnn_result_o(result), .bnn_ready_o(ready),
        .prm_we_i(prm_we), .prm_waddr_i(prm_waddr), .prm_lane_i(prm_lane), .prm_wdata_i(prm_wdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int sx16(input logic [31:0] v);
        logic signed [15:0] t;
        t = v[15:0];
        return int'(t);
    endfunction

    function automatic int fit(input longint v);
        logic signed [15:0] t;
        if (SAT) begin
            if (v > 32767)  return 32767;
            if (v < -32768) return -32768;
            return int'(v);
        end
        t = v[15:0];
        return int'(t);
    endfunction

    task automatic model_reset();
        for (int g = 0; g < NCORE; g++) begin
            m_acc[g]  = 0;
            m_pool[g] = -32768;
        end
    endtask

    task automatic model_step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        int row;
        logic [31:0] w;
        row = int'(a[7:0]);
        for (int g = 0; g < NCORE; g++) begin
            w = m_w[row][g];
            case (op)
                3'd0: begin m_acc[g] = sx16(d); m_pool[g] = -32768; end
                3'd1: m_acc[g] = fit(longint'(m_acc[g]) + 2 * $countones(~(d ^ w)));
                3'd2: begin
                    if (m_acc[g] > m_pool[g]) m_pool[g] = m_acc[g];
                    m_acc[g] = sx16(d);
                end
                3'd3: m_pool[g] = fit(longint'(m_pool[g]) * 64 - sx16(w));
                3'd4: m_res[g] = (m_pool[g] < 0);
                default: ;
            endcase
        end
    endtask

    task automatic wr(input int row, input int lane, input logic [31:0] val);
        prm_we = 1'b1; prm_waddr = 8'(row); prm_lane = 5'(lane); prm_wdata = val;
        @(posedge clk); #1;
        prm_we = 1'b0;
        m_w[row][lane] = val;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                         output int waits);
        logic rdy;
        bit   ok;
        ok = 1'b0; waits = 0;
        bnn_en = 1'b1; opr = op; addr = a; data = d;
        for (int i = 0; i < 10; i++) begin
            rdy = ready;
            @(posedge clk); #1;
            waits++;
            if (rdy) begin ok = 1'b1; break; end
        end
        bnn_en = 1'b0;
        chk("accept", {31'b0, ok}, 32'd1);
        model_step(op, a, d);
    endtask

    task automatic op1(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        int w;
        issue(op, a, d, w);
    endtask

    task automatic pop_chk(input string tag);
        logic [31:0] e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk(tag, result, e);
        end
    endtask

    task automatic activ(input string tag);
        op1(3'd4, 32'd0, 32'd0);
        sb.push_back(m_res);
        chk({tag, "_rdy_e0"}, {31'b0, ready}, 32'd0);
        @(posedge clk); #1;
        chk({tag, "_rdy_e1"}, {31'b0, ready}, 32'd0);
        @(posedge clk); #1;
        chk({tag, "_rdy_e2"}, {31'b0, ready}, 32'd1);
        pop_chk(tag);
    endtask

    initial begin
        int w;
        logic [31:0] prev;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", result, 32'd0);
        chk("rst_ready", {31'b0, ready}, 32'd1);
        rst_n = 1'b1;
        model_reset();

        for (int g = 0; g < NCORE; g++) begin
            wr(0, g, (g == 0) ? 32'hFFFF_FFFF : $urandom);
            wr(5, g, (g == 3) ? ~D : $urandom);
            wr(7, g, (g == 0) ? 32'h0 : $urandom);
        end

        activ("activ_rst");
        chk("activ_rst_all", result, 32'hFFFF_FFFF);

        op1(3'd0, 32'd0, 32'hFFFF_FFD8);
        op1(3'd1, 32'd0, 32'hFFFF_FFFF);
        op1(3'd2, 32'd0, 32'd0);
        activ("pos24");
        chk("pos24_bit0", {31'b0, result[0]}, 32'd0);

        op1(3'd0, 32'd0, 32'hFFFF_FFB0);
        op1(3'd1, 32'd0, 32'hFFFF_FFFF);
        op1(3'd2, 32'd0, 32'd0);
        activ("neg16");
        chk("neg16_bit0", {31'b0, result[0]}, 32'd1);
        op1(3'd3, 32'd7, 32'd0);
        activ("norm1");
        chk("norm1_bit0", {31'b0, result[0]}, 32'd1);
        op1(3'd3, 32'd7, 32'd0);
        activ("norm2");
        chk("norm2_bit0", {31'b0, result[0]}, SAT ? 32'd1 : 32'd0);

        op1(3'd0, 32'd0, 32'h0000_7FF0);
        op1(3'd1, 32'd0, 32'hFFFF_FFFF);
        op1(3'd2, 32'd0, 32'd0);
        activ("acc_ovf");
        chk("acc_ovf_bit0", {31'b0, result[0]}, SAT ? 32'd0 : 32'd1);

        op1(3'd0, 32'd0, 32'hFFFF_FF9C);
        issue(3'd4, 32'd0, 32'd0, w);
        sb.push_back(m_res);
        issue(3'd1, 32'd0, 32'hFFFF_FFFF, w);
        chk("held_waits", 32'(w), 32'd3);
        pop_chk("held_activ");
        op1(3'd2, 32'd0, 32'd0);
        activ("held_once");
        chk("held_once_bit0", {31'b0, result[0]}, 32'd1);

        prev = result;
        op1(3'd5, 32'd0, 32'h1234_5678);
        op1(3'd6, 32'd5, 32'h0000_7FFF);
        op1(3'd7, 32'd7, 32'h8000_0000);
        chk("nop_hold", result, prev);
        activ("nop_activ");

        op1(3'd0, 32'd5, 32'hFFFF_FFD8);
        prm_we = 1'b1; prm_waddr = 8'd5; prm_lane = 5'd3; prm_wdata = D;
        op1(3'd1, 32'd5, D);
        prm_we = 1'b0;
        m_w[5][3] = D;
        op1(3'd2, 32'd5, 32'd0);
        activ("rf_old");
        chk("rf_old_bit3", {31'b0, result[3]}, 32'd1);
        op1(3'd0, 32'd5, 32'hFFFF_FFD8);
        op1(3'd1, 32'd261, D);
        op1(3'd2, 32'd5, 32'd0);
        activ("rf_new_wrap");
        chk("rf_new_bit3", {31'b0, result[3]}, 32'd0);

        op1(3'd4, 32'd0, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_result", result, 32'd0);
        chk("midrst_ready", {31'b0, ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_abort", result, 32'd0);
        activ("post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
